count_seq_ctrl: RTL and testbench

//  Load sequencer/arbiter for the loadable 4-bit free-running counter (register+increment+transfer).
//  Two requesters share the counter's single load port via round-robin arbitration.

---
 rtl/count_seq_pkg.sv | 12 +
 rtl/rr_arb2.sv | 33 +++
 rtl/count_seq_ctrl.sv | 108 ++++++++++
 tb/tb_count_seq_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared state type and width constant for the counter load sequencer
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; pointer holds the last winner
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       update_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = ptr_q ? 2'b01 : 2'b10;
    end
    ptr_d = ptr_q;
    if (update_i && (|req_i)) begin
      ptr_d = gnt_o[1];
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - load sequencer for a loadable counter: arbitrate, load, verify, ack
// Optional terminal-count flag enabled by COUNT_SEQ_CTRL_TC_EN.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int                 WIDTH  = WIDTH_DEF,
  parameter logic [WIDTH-1:0]   TC_VAL = '1
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] val0_i,
  input  logic [WIDTH-1:0] val1_i,
  output logic [1:0]       ack_o,
  input  logic [WIDTH-1:0] count_i,
  output logic             load_o,
  output logic [WIDTH-1:0] value_o,
  output logic             err_o,
  output logic             tc_o
);

  state_e           state_q;
  logic             win_q;
  logic [WIDTH-1:0] val_q;
  logic [1:0]       ack_q;
  logic             load_q;
  logic [WIDTH-1:0] value_q;
  logic             err_q;

  logic [1:0]       gnt;
  logic             grant;
  logic [WIDTH-1:0] sel_val;

  assign grant   = (state_q == IDLE) && (|req_i);
  assign sel_val = gnt[0] ? val0_i : val1_i;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .req_i    (req_i),
    .update_i (grant),
    .gnt_o    (gnt)
  );

  // The counter takes value_o on the edge that ends LOAD, so CHECK sees the loaded value.
  // The ack is registered on entry to CHECK; the verdict lands in err_q as CHECK ends.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      val_q   <= '0;
      ack_q   <= 2'b00;
      load_q  <= 1'b0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ack_q   <= 2'b00;
      load_q  <= 1'b0;
      value_q <= '0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            win_q   <= gnt[1];
            val_q   <= sel_val;
            load_q  <= 1'b1;
            value_q <= sel_val;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          ack_q   <= win_q ? 2'b10 : 2'b01;
          state_q <= CHECK;
        end
        CHECK: begin
          if (count_i != val_q) begin
            err_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign load_o  = load_q;
  assign value_o = value_q;
  assign err_o   = err_q;

`ifdef COUNT_SEQ_CTRL_TC_EN
  logic tc_q;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= (state_q == IDLE) && (count_i == TC_VAL);
    end
  end

  assign tc_o = tc_q;
`else
  logic unused_tc_val;
  assign unused_tc_val = ^TC_VAL;
  assign tc_o          = 1'b0;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - directed self-checking bench for count_seq_ctrl with a counter model
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [1:0] req_i;
  logic [3:0] val0_i;
  logic [3:0] val1_i;
  logic [1:0] ack_o;
  logic       load_o;
  logic [3:0] value_o;
  logic       err_o;
  logic       tc_o;

  logic [3:0] cnt   = 4'h0;
  bit         fault = 1'b0;

  int errors = 0;
  int checks = 0;

  count_seq_ctrl #(.WIDTH(4), .TC_VAL(4'hF)) dut (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .val0_i  (val0_i),
    .val1_i  (val1_i),
    .ack_o   (ack_o),
    .count_i (cnt),
    .load_o  (load_o),
    .value_o (value_o),
    .err_o   (err_o),
    .tc_o    (tc_o)
  );

  always #5 clk = ~clk;

  // Free-running loadable counter; in fault mode it ignores the load port.
  always @(posedge clk) begin
    if (load_o && !fault) cnt <= value_o;
    else                  cnt <= cnt + 4'h1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #1;
    tick();
    rst_ni = 1'b1;
  endtask

  // Expects the grant edge to be the next edge; returns in IDLE after the ack.
  task automatic expect_seq(input string tag, input int idx, input logic [3:0] v,
                            input logic exp_err);
    tick();
    check_eq({tag, "_load"},  load_o,  1'b1);
    check_eq({tag, "_value"}, value_o, v);
    check_eq({tag, "_noack"}, ack_o,   2'b00);
    tick();
    check_eq({tag, "_ack"},   ack_o,   (idx == 1) ? 2'b10 : 2'b01);
    check_eq({tag, "_load0"}, load_o,  1'b0);
    tick();
    check_eq({tag, "_ackoff"}, ack_o,  2'b00);
    check_eq({tag, "_err"},    err_o,  exp_err);
  endtask

  initial begin
    logic [3:0] prev;
    logic       exp_tc;
    int         tc_seen;

    rst_ni = 1'b0;
    req_i  = 2'b00;
    val0_i = 4'h0;
    val1_i = 4'h0;

    // 1: reset values, then reset aborting a LOAD
    tick();
    tick();
    check_eq("rst_ack",   ack_o,   2'b00);
    check_eq("rst_load",  load_o,  1'b0);
    check_eq("rst_value", value_o, 4'h0);
    check_eq("rst_err",   err_o,   1'b0);
    check_eq("rst_tc",    tc_o,    1'b0);
    rst_ni = 1'b1;
    req_i  = 2'b01;
    val0_i = 4'h5;
    tick();
    check_eq("pre_abort_load", load_o, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("abort_load",  load_o,  1'b0);
    check_eq("abort_value", value_o, 4'h0);
    tick();
    rst_ni = 1'b1;
    check_eq("abort_noack", ack_o, 2'b00);
    expect_seq("rearb", 0, 4'h5, 1'b0);
    req_i = 2'b00;
    tick();
    check_eq("idle_noload", load_o, 1'b0);

    // 2: single load from requester 0
    req_i  = 2'b01;
    val0_i = 4'h9;
    expect_seq("single", 0, 4'h9, 1'b0);
    req_i = 2'b00;

    // 3: contention from reset alternates 0,1,0,1
    do_reset();
    req_i  = 2'b11;
    val0_i = 4'h3;
    val1_i = 4'hC;
    for (int i = 0; i < 4; i++) begin
      expect_seq((i % 2 == 0) ? "rr0" : "rr1", i % 2, (i % 2 == 0) ? 4'h3 : 4'hC, 1'b0);
    end
    req_i = 2'b00;
    tick();

    // 4: counter ignores load -> sticky error, ack still given
    fault  = 1'b1;
    req_i  = 2'b01;
    val0_i = cnt + 4'h5;
    expect_seq("fault", 0, val0_i, 1'b1);
    req_i = 2'b00;
    fault = 1'b0;
    req_i  = 2'b10;
    val1_i = 4'h7;
    expect_seq("sticky", 1, 4'h7, 1'b1);
    req_i = 2'b00;
    do_reset();
    check_eq("err_cleared", err_o, 1'b0);

    // 5: load F then wrap; load 0
    req_i  = 2'b10;
    val1_i = 4'hF;
    tick();
    check_eq("wrap_load",  load_o,  1'b1);
    check_eq("wrap_value", value_o, 4'hF);
    tick();
    check_eq("wrap_ack",   ack_o,   2'b10);
    check_eq("wrap_tc_ld", tc_o,    1'b0);
    tick();
    check_eq("wrap_err",   err_o,   1'b0);
    check_eq("wrap_tc_ck", tc_o,    1'b0);
    req_i = 2'b00;
    tick();
    check_eq("wrap_err2",  err_o,   1'b0);
    req_i  = 2'b01;
    val0_i = 4'h0;
    expect_seq("zero", 0, 4'h0, 1'b0);
    req_i = 2'b00;

    // 6: terminal count while idle
    tc_seen = 0;
    prev    = cnt;
    for (int i = 0; i < 18; i++) begin
      tick();
`ifdef COUNT_SEQ_CTRL_TC_EN
      exp_tc = (prev == 4'hF);
`else
      exp_tc = 1'b0;
`endif
      check_eq("tc_idle", tc_o, exp_tc);
      if (tc_o) tc_seen++;
      prev = cnt;
    end
`ifdef COUNT_SEQ_CTRL_TC_EN
    check_eq("tc_seen", tc_seen, 1);
`else
    check_eq("tc_seen", tc_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
